// File: rtl/fetch_stage.sv
// fetch_stage: program counter generator and IF/ID pipeline register that sits
// directly in front of the instruction memory.
//
// It drives the memory address and read enable. The returned word is captured
// on the next rising edge and handed to decode, together with pc+1 and a valid
// flag. The block also handles hazard stalls, redirects (flush) and halt
// detection. The PC is word-addressed: each address holds one instruction.
//
// Ports
//   clk            system clock, rising-edge
//   rst            synchronous active-high reset
//   stall          hold PC and the IF/ID register
//   flush          redirect to branch_target and squash the in-flight word
//   branch_target  redirect PC
//   imem_instr     instruction word returned for imem_addr
//   imem_addr      instruction memory address (the pc register)
//   imem_rd_en     instruction memory read enable
//   if_instr       registered instruction to decode
//   if_pc_plus1    registered address of the fetched instruction + 1
//   if_valid       if_instr holds a real instruction
//   halted         high while in HALT
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | issuing one read per unstalled cycle, pc advancing
// HALT  | HLT delivered; pc parked on the HLT address until flush/reset

module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    input  logic [15:0] imem_instr,
    output logic [15:0] imem_addr,
    output logic        imem_rd_en,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HALT  = 1'b1;

    logic [0:0]  state;
    logic [15:0] pc;
    logic [15:0] pc_plus1;

    // 16-bit modulo add: 16'hFFFF wraps to 16'h0000.
    assign pc_plus1   = pc + 16'd1;

    assign imem_addr  = pc;
    assign imem_rd_en = (state == ST_FETCH) & ~stall & ~rst;
    assign halted     = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            state       <= ST_FETCH;
            if_instr    <= NOP_INSTR;
            if_pc_plus1 <= 16'h0000;
            if_valid    <= 1'b0;
        end else if (flush) begin
            // Redirect wins over stall. The word read this cycle belongs to
            // the wrong path, so drop it. if_pc_plus1 keeps its value because
            // if_valid=0 makes it meaningless.
            pc       <= branch_target;
            state    <= ST_FETCH;
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (stall) begin
            // Everything holds.
        end else if (state == ST_FETCH) begin
            if_instr    <= imem_instr;
            if_pc_plus1 <= pc_plus1;
            if_valid    <= 1'b1;
            if (imem_instr[15:12] == HALT_OPCODE) begin
                // Park on the HLT address; HLT itself goes out exactly once.
                state <= ST_HALT;
            end else begin
                pc <= pc_plus1;
            end
        end else begin
            if_instr <= NOP_INSTR;
            if_valid <= 1'b0;
        end
    end

endmodule
